// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: access-size codes and FSM state encodings.
package data_mem_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_BAD  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_MERGE  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU load/store port: request held by the CPU until a one-cycle done pulse from the responder.
interface data_mem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        data_size;
    logic              data_sign;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;

    modport master (
        output req_valid, mem_read, mem_write, data_size, data_sign, addr, wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req_valid, mem_read, mem_write, data_size, data_sign, addr, wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/data_mem_responder_sram.sv
// Synchronous single-port 32-bit RAM with registered read data; contents are not reset.
module sram_1rw #(
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port (read-before-write on a same-address write)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'd0;
        end else begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store port: wait states, lane steering, load extension
// and read-modify-write for sub-word stores over a word-wide SRAM.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);

    state_e             state_r, state_s;
    logic [3:0]         cnt_r, cnt_s;
    logic               busy_r, done_r, done_s, err_r, err_s;
    logic [31:0]        rdata_r, rdata_s;
    logic               latch_s, reject_s;

    logic               rd_r, wr_r, sign_r;
    logic [1:0]         size_r, lane_r;
    logic [IDX_W-1:0]   idx_r;
    logic [31:0]        wdata_r;

    logic               sram_we_s;
    logic [31:0]        sram_wdata_s, sram_rdata_s;
    logic [7:0]         byte_s;
    logic [15:0]        half_s;
    logic [31:0]        load_s, merge_s;

    sram_1rw #(.DEPTH(DEPTH), .AW(IDX_W)) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (sram_we_s),
        .addr  (idx_r),
        .wdata (sram_wdata_s),
        .rdata (sram_rdata_s)
    );

    // Request legality check on the live inputs, evaluated at acceptance
    always_comb begin
        reject_s = 1'b0;
        if (bus.mem_read == bus.mem_write) begin
            reject_s = 1'b1;
        end else if (bus.data_size == SIZE_BAD) begin
            reject_s = 1'b1;
        end else if ((bus.data_size == SIZE_HALF) && bus.addr[0]) begin
            reject_s = 1'b1;
        end else if ((bus.data_size == SIZE_WORD) && (bus.addr[1:0] != 2'd0)) begin
            reject_s = 1'b1;
        end else begin
            reject_s = (bus.addr[ADDR_W-1:2] >= DEPTH_LIM);
        end
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        byte_s = sram_rdata_s[7:0];
        case (lane_r)
            2'd0:    byte_s = sram_rdata_s[7:0];
            2'd1:    byte_s = sram_rdata_s[15:8];
            2'd2:    byte_s = sram_rdata_s[23:16];
            2'd3:    byte_s = sram_rdata_s[31:24];
            default: byte_s = sram_rdata_s[7:0];
        endcase
        half_s = lane_r[1] ? sram_rdata_s[31:16] : sram_rdata_s[15:0];
        load_s = sram_rdata_s;
        case (size_r)
            SIZE_BYTE: load_s = {{24{sign_r & byte_s[7]}}, byte_s};
            SIZE_HALF: load_s = {{16{sign_r & half_s[15]}}, half_s};
            default:   load_s = sram_rdata_s;
        endcase
    end

    // Sub-word store merge of the new lane into the word read in ACCESS
    always_comb begin
        merge_s = sram_rdata_s;
        case (size_r)
            SIZE_BYTE: begin
                case (lane_r)
                    2'd0:    merge_s = {sram_rdata_s[31:8], wdata_r[7:0]};
                    2'd1:    merge_s = {sram_rdata_s[31:16], wdata_r[7:0], sram_rdata_s[7:0]};
                    2'd2:    merge_s = {sram_rdata_s[31:24], wdata_r[7:0], sram_rdata_s[15:0]};
                    default: merge_s = {wdata_r[7:0], sram_rdata_s[23:0]};
                endcase
            end
            SIZE_HALF: merge_s = lane_r[1] ? {wdata_r[15:0], sram_rdata_s[15:0]}
                                           : {sram_rdata_s[31:16], wdata_r[15:0]};
            default:   merge_s = wdata_r;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        done_s       = 1'b0;
        err_s        = 1'b0;
        rdata_s      = rdata_r;
        latch_s      = 1'b0;
        sram_we_s    = 1'b0;
        sram_wdata_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    latch_s = 1'b1;
                    if (reject_s) begin
                        state_s = ST_RESP;
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                        rdata_s = 32'd0;
                    end else if (WAIT_INIT == 4'd0) begin
                        state_s = ST_ACCESS;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = WAIT_INIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                // Word stores finish here; everything else needs the read word in MERGE
                if (wr_r && (size_r == SIZE_WORD)) begin
                    sram_we_s    = 1'b1;
                    sram_wdata_s = wdata_r;
                    state_s      = ST_RESP;
                    done_s       = 1'b1;
                end else begin
                    state_s = ST_MERGE;
                end
            end
            ST_MERGE: begin
                if (rd_r) begin
                    rdata_s = load_s;
                end else begin
                    sram_we_s    = 1'b1;
                    sram_wdata_s = merge_s;
                end
                state_s = ST_RESP;
                done_s  = 1'b1;
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs and request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            sign_r  <= 1'b0;
            size_r  <= 2'd0;
            lane_r  <= 2'd0;
            idx_r   <= '0;
            wdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= done_s;
            err_r   <= err_s;
            rdata_r <= rdata_s;
            if (latch_s) begin
                rd_r    <= bus.mem_read;
                wr_r    <= bus.mem_write;
                sign_r  <= bus.data_sign;
                size_r  <= bus.data_size;
                lane_r  <= bus.addr[1:0];
                idx_r   <= bus.addr[IDX_W+1:2];
                wdata_r <= bus.wdata;
            end
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a transaction-level memory model.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int WS    = 2;
    localparam int DEPTH = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(32)) bus   ();
    data_mem_responder_if #(.ADDR_W(32)) bus_z ();
    data_mem_responder_if #(.ADDR_W(32)) bus_f ();

    data_mem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    data_mem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst_n(rst_n), .bus(bus_z));
    data_mem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(5)) u_dut_ws5 (
        .clk(clk), .rst_n(rst_n), .bus(bus_f));

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mm [DEPTH];
    logic [31:0] last_rdata = 32'd0;
    bit          gap = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%b expected=%b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: result, latency, and memory side effect of one request
    function automatic void model(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output bit e, output logic [31:0] r, output int lat);
        int          wi;
        int          nbytes;
        logic [4:0]  sh;
        logic [31:0] mask, v;
        wi = int'(a[31:2]);
        e  = (rd == wr) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
             (sz == 2'd2 && a[1:0] != 2'd0) || (wi >= DEPTH);
        if (e) begin
            r   = 32'd0;
            lat = 1;
            return;
        end
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        sh     = {a[1:0], 3'b000};
        if (rd) begin
            v = (mm[wi[7:0]] >> sh) & mask;
            if (sg && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
            r   = v;
            lat = WS + 3;
        end else begin
            mm[wi[7:0]] = (mm[wi[7:0]] & ~(mask << sh)) | ((wd & mask) << sh);
            r   = last_rdata;
            lat = (nbytes == 4) ? WS + 2 : WS + 3;
        end
    endfunction

    task automatic idle_cycle();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chkb("idle_busy", bus.busy, 1'b0);
        chkb("idle_done", bus.done, 1'b0);
        chk("idle_rdata", bus.rdata, last_rdata);
        gap = 1'b0;
    endtask

    // Issue one request, hold it, and check every cycle up to and including done
    task automatic run_txn(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input bit pin, input logic [31:0] pin_rd, input int pin_lat);
        bit          e;
        logic [31:0] r;
        int          lat;
        bus.req_valid = 1'b1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.data_size = sz;
        bus.data_sign = sg;
        bus.addr      = a;
        bus.wdata     = wd;
        if (gap) begin
            @(negedge clk);
            chkb("gap_busy", bus.busy, 1'b0);
            chkb("gap_done", bus.done, 1'b0);
            chk("gap_rdata", bus.rdata, last_rdata);
        end
        model(rd, wr, sz, sg, a, wd, e, r, lat);
        if (pin) begin
            chk("model_rdata_pin", r, pin_rd);
            chk("model_lat_pin", 32'(lat), 32'(pin_lat));
            r   = pin_rd;
            lat = pin_lat;
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chkb("busy", bus.busy, 1'b1);
            chkb("done", bus.done, (k == lat));
            chkb("err", bus.err, (k == lat) && e);
            chk("rdata", bus.rdata, (k == lat) ? r : last_rdata);
            if (k == 1 && lat > 1) begin
                bus.addr      = $urandom;
                bus.wdata     = $urandom;
                bus.data_size = 2'($urandom_range(0, 3));
                bus.data_sign = ~sg;
                bus.mem_read  = ~rd;
            end
        end
        last_rdata = r;
        gap        = 1'b1;
    endtask

    task automatic aux_probe(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input int lat_z, input int lat_f);
        bus_z.req_valid = 1'b1; bus_z.mem_read = rd; bus_z.mem_write = ~rd;
        bus_z.data_size = SIZE_WORD; bus_z.data_sign = 1'b0; bus_z.addr = a; bus_z.wdata = wd;
        bus_f.req_valid = 1'b1; bus_f.mem_read = rd; bus_f.mem_write = ~rd;
        bus_f.data_size = SIZE_WORD; bus_f.data_sign = 1'b0; bus_f.addr = a; bus_f.wdata = wd;
        for (int k = 1; k <= lat_f + 1; k++) begin
            @(negedge clk);
            chkb("ws0_busy", bus_z.busy, (k <= lat_z));
            chkb("ws0_done", bus_z.done, (k == lat_z));
            chkb("ws5_busy", bus_f.busy, (k <= lat_f));
            chkb("ws5_done", bus_f.done, (k == lat_f));
            if (k == lat_z) begin
                if (rd) chk("ws0_rdata", bus_z.rdata, exp_rd);
                bus_z.req_valid = 1'b0;
            end
            if (k == lat_f) begin
                if (rd) chk("ws5_rdata", bus_f.rdata, exp_rd);
                bus_f.req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        int          x, w;
        bit          rd, wr;
        logic [31:0] a;
        bus.req_valid   = 1'b0; bus.mem_read   = 1'b0; bus.mem_write   = 1'b0;
        bus.data_size   = 2'd0; bus.data_sign   = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
        bus_z.req_valid = 1'b0; bus_z.mem_read = 1'b0; bus_z.mem_write = 1'b0;
        bus_z.data_size = 2'd0; bus_z.data_sign = 1'b0; bus_z.addr = 32'd0; bus_z.wdata = 32'd0;
        bus_f.req_valid = 1'b0; bus_f.mem_read = 1'b0; bus_f.mem_write = 1'b0;
        bus_f.data_size = 2'd0; bus_f.data_sign = 1'b0; bus_f.addr = 32'd0; bus_f.wdata = 32'd0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chkb("rst_busy", bus.busy, 1'b0);
        chkb("rst_done", bus.done, 1'b0);
        chkb("rst_err", bus.err, 1'b0);
        chk("rst_rdata", bus.rdata, 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // Word store then load back
        run_txn(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0, 4);
        run_txn(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 5);

        // Byte store into the middle of a word, then signed/unsigned/word reads
        run_txn(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h04, 32'h1122_3344, 1'b1, 32'hDEAD_BEEF, 4);
        run_txn(1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h05, 32'hAABB_CC80, 1'b1, 32'hDEAD_BEEF, 5);
        run_txn(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h05, 32'h0, 1'b1, 32'hFFFF_FF80, 5);
        run_txn(1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h05, 32'h0, 1'b1, 32'h0000_0080, 5);
        run_txn(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h04, 32'h0, 1'b1, 32'h1122_8044, 5);

        // Rejections: misaligned half, out-of-range word, out-of-range store that must not alias
        run_txn(1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h03, 32'h0, 1'b1, 32'h0, 1);
        run_txn(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h402, 32'h0, 1'b1, 32'h0, 1);
        run_txn(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h400, 32'h5555_5555, 1'b1, 32'h0, 1);
        run_txn(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h04, 32'h0, 1'b1, 32'h1122_8044, 5);
        run_txn(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0, 0);

        // Fill the region used by random traffic: words 0..15 and 252..255
        for (int i = 0; i < 20; i++) begin
            w = (i < 16) ? i : 236 + i;
            run_txn(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'(w * 4), $urandom, 1'b0, 32'h0, 0);
        end

        // Reset during the WAIT of a half store leaves memory untouched
        idle_cycle();
        run_txn(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0, 0);
        idle_cycle();
        bus.req_valid = 1'b1; bus.mem_read = 1'b0; bus.mem_write = 1'b1;
        bus.data_size = SIZE_HALF; bus.data_sign = 1'b0; bus.addr = 32'h08; bus.wdata = 32'h0000_BEEF;
        @(negedge clk);
        chkb("midrst_busy_before", bus.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chkb("midrst_busy_async", bus.busy, 1'b0);
        chkb("midrst_done", bus.done, 1'b0);
        chk("midrst_rdata", bus.rdata, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        last_rdata = 32'd0;
        gap        = 1'b0;
        idle_cycle();
        run_txn(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0, 0);

        // Random traffic, mostly back-to-back with req_valid held through done
        for (int i = 0; i < 300; i++) begin
            x = $urandom_range(0, 19);
            rd = (x == 1) ? 1'b1 : (x == 0) ? 1'b0 : x[0];
            wr = (x == 0) ? 1'b0 : (x == 1) ? 1'b1 : ~x[0];
            x = $urandom_range(0, 9);
            if (x < 7)      w = $urandom_range(0, 15);
            else if (x < 9) w = $urandom_range(252, 255);
            else            w = $urandom_range(256, 400);
            a = 32'(w * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle_cycle();
            run_txn(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
                    1'b0, 32'h0, 0);
        end
        idle_cycle();

        // Wait-state extremes on the top word
        aux_probe(1'b0, 32'h3FC, 32'hCAFE_F00D, 32'h0, 2, 7);
        aux_probe(1'b1, 32'h3FC, 32'h0, 32'hCAFE_F00D, 3, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
